// File: rtl/unified_block_memory.sv
// unified_block_memory: multi-port block memory with one arbitrated, fixed-latency access in flight.
// Define UNIFIED_BLOCK_MEMORY_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round robin.
module unified_block_memory #(
  parameter int NUM_PORTS   = 2,
  parameter int BLOCK_WIDTH = 128,
  parameter int ADDR_WIDTH  = 28,
  parameter int DEPTH       = 256,
  parameter int LATENCY     = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [NUM_PORTS-1:0]             READ,
  input  logic [NUM_PORTS-1:0]             WRITE,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ADDRESS,
  input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] WRITEDATA,
  output logic [NUM_PORTS*BLOCK_WIDTH-1:0] READDATA,
  output logic [NUM_PORTS-1:0]             BUSYWAIT
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [NUM_PORTS-1:0] req, ack, elig;
  logic [BLOCK_WIDTH-1:0] mem [DEPTH];
  logic [BLOCK_WIDTH-1:0] wdata;
  logic [PW-1:0] port, gnt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic op_wr, found, grant;
  assign req = READ | WRITE;
  // a port that was just acked must not be re-served by its still-held request
  assign elig = req & ~ack;
  assign BUSYWAIT = req & ~ack;
  assign grant = state == IDLE && found;
`ifdef UNIFIED_BLOCK_MEMORY_FIXED_PRIORITY_EN
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (elig[i]) begin
        gnt = PW'(i);
        found = 1'b1;
      end
  end
`else
  logic [PW-1:0] ptr;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++)
      for (int i = 0; i < NUM_PORTS; i++)
        if (!found && elig[i] && (i - int'(ptr) + NUM_PORTS) % NUM_PORTS == k) begin
          gnt = PW'(i);
          found = 1'b1;
        end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) ptr <= '0;
    else if (grant) ptr <= int'(gnt) == NUM_PORTS - 1 ? '0 : gnt + 1'b1;
`endif
  always_comb state_n = state == IDLE ? (found ? ACCESS : IDLE) : (cnt == '0 ? IDLE : ACCESS);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      ack <= '0;
      cnt <= '0;
      port <= '0;
      idx <= '0;
      wdata <= '0;
      op_wr <= 1'b0;
      READDATA <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        port <= gnt;
        op_wr <= WRITE[gnt];
        idx <= ADDRESS[int'(gnt)*ADDR_WIDTH +: IW];
        wdata <= WRITEDATA[int'(gnt)*BLOCK_WIDTH +: BLOCK_WIDTH];
        cnt <= CW'(LATENCY - 1);
      end else if (state == ACCESS) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          ack[port] <= 1'b1;
          if (op_wr) mem[idx] <= wdata;
          else READDATA[int'(port)*BLOCK_WIDTH +: BLOCK_WIDTH] <= mem[idx];
        end
      end
    end
endmodule
